// File: rtl/fold_stream_ctrl_pkg.sv
// Shared definitions for the folding-reducer stream controller:
// fold split point, default modulus, datapath width and FSM states.
package fold_stream_ctrl_pkg;

    localparam int DATAWIDTH    = 16;
    localparam int FOLD_SPLIT   = 13;
    localparam int MODQ_DEFAULT = (1 << FOLD_SPLIT) - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fsc_state_e;

endpackage

// File: rtl/fold_stream_ctrl_canon_sub.sv
// Combinational conditional subtract that brings a folded value into [0, MODQ-1].
// A single subtract is enough because folded values never reach 2*MODQ.
module canon_sub
    import fold_stream_ctrl_pkg::*;
#(
    parameter int DW   = DATAWIDTH,
    parameter int MODQ = MODQ_DEFAULT
) (
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    localparam logic [DW-1:0] MODQ_W = DW'(MODQ);

    always_comb begin
        dout = (din >= MODQ_W) ? (din - MODQ_W) : din;
    end

endmodule

// File: rtl/fold_stream_ctrl.sv
// Streams LEN coefficients from RAM through the 1-cycle folding reducer and
// writes the (optionally canonicalised) results back in place.
module fold_stream_ctrl
    import fold_stream_ctrl_pkg::*;
#(
    parameter int DW    = DATAWIDTH,
    parameter int AW    = 8,
    parameter int MODQ  = MODQ_DEFAULT,
    parameter int CANON = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] c_out,
    output logic          en_out,
    input  logic [DW-1:0] e_in,
    input  logic          rdy_in,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          done,
    output logic          err
);

    fsc_state_e    state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   rd_cnt_q, rd_cnt_d;
    logic [AW:0]   wr_cnt_q, wr_cnt_d;
    logic [AW:0]   outst_q, outst_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] pipe1_q, pipe1_d;
    logic [AW-1:0] pipe2_q, pipe2_d;
    logic          en_q, en_d;
    logic          err_q, err_d;

    logic          run;
    logic          busy_w;
    logic          wr_fire;
    logic [DW-1:0] wr_val;

    if (CANON != 0) begin : g_canon
        canon_sub #(
            .DW   (DW),
            .MODQ (MODQ)
        ) u_canon_sub (
            .din  (e_in),
            .dout (wr_val)
        );
    end else begin : g_raw
        assign wr_val = e_in;
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        rd_cnt_d = rd_cnt_q;
        addr_d   = addr_q;

        run     = (state_q == ST_RUN);
        busy_w  = run || (state_q == ST_DRAIN);
        // A result is only accepted when an element is actually in flight.
        wr_fire = rdy_in && busy_w && (outst_q != '0);
        err_d   = err_q | (rdy_in & ~wr_fire);

        wr_cnt_d = wr_cnt_q + (AW+1)'(wr_fire);
        outst_d  = outst_q + (AW+1)'(en_q) - (AW+1)'(wr_fire);
        en_d     = run;
        pipe1_d  = run ? addr_q : '0;
        pipe2_d  = pipe1_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d    = len;
                    addr_d   = base;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                    outst_d  = '0;
                    state_d  = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                addr_d   = addr_q + 1'b1;
                rd_cnt_d = rd_cnt_q + 1'b1;
                if ((rd_cnt_q + 1'b1) == len_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wr_cnt_d == len_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            outst_q  <= '0;
            addr_q   <= '0;
            pipe1_q  <= '0;
            pipe2_q  <= '0;
            en_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            outst_q  <= outst_d;
            addr_q   <= addr_d;
            pipe1_q  <= pipe1_d;
            pipe2_q  <= pipe2_d;
            en_q     <= en_d;
            err_q    <= err_d;
        end
    end

    // Data outputs are gated by their strobes so everything reads 0 in reset.
    always_comb begin
        rd_en   = run;
        rd_addr = run ? addr_q : '0;
        en_out  = en_q;
        c_out   = en_q ? rd_data : '0;
        wr_en   = wr_fire;
        wr_addr = pipe2_q;
        wr_data = wr_fire ? wr_val : '0;
        busy    = busy_w;
        done    = (state_q == ST_DONE);
        err     = err_q;
    end

endmodule
